// File: rtl/ppc_sum_if.sv
// ----------------------------------------------------------------------------
// ppc_sum_if -- bundle between the prefix pipeline / result consumer and
// ppc_sum_unit.
//
// Signals:
//   in_valid  : a resolved prefix word is present this cycle (never stalled)
//   y         : per-bit resolved carry code, 'k'=8'h6B, 'g'=8'h67, 'p'=8'h70
//   a, b      : operands aligned with y
//   out_valid : result buffer head holds a result
//   out_ready : consumer accepts the head this cycle
//   sum, cout, ovf : result at the buffer head
//   in_drop   : one-cycle pulse after an input word was discarded
//   err       : sticky illegal-code flag (present only with PPC_SUM_ERRCHK_EN)
//
// Modports: master = producer/consumer side, slave = ppc_sum_unit.
// Optional feature macro: PPC_SUM_ERRCHK_EN.
// ----------------------------------------------------------------------------
interface ppc_sum_if;
    logic             in_valid;
    logic [31:0][7:0] y;
    logic [31:0]      a;
    logic [31:0]      b;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      sum;
    logic             cout;
    logic             ovf;
    logic             in_drop;
`ifdef PPC_SUM_ERRCHK_EN
    logic             err;

    modport master (
        output in_valid, y, a, b, out_ready,
        input  out_valid, sum, cout, ovf, in_drop, err
    );
    modport slave (
        input  in_valid, y, a, b, out_ready,
        output out_valid, sum, cout, ovf, in_drop, err
    );
`else
    modport master (
        output in_valid, y, a, b, out_ready,
        input  out_valid, sum, cout, ovf, in_drop
    );
    modport slave (
        input  in_valid, y, a, b, out_ready,
        output out_valid, sum, cout, ovf, in_drop
    );
`endif
endinterface

// File: rtl/ppc_sum_unit.sv
// ----------------------------------------------------------------------------
// ppc_sum_unit -- final sum stage of a parallel-prefix adder followed by a
// small result FIFO.
//
// The sum bits are formed from the resolved carry codes y (carry into bit i is
// "bit i-1 generates"), then {sum,cout,ovf} is pushed into a DEPTH-entry FIFO.
// The input side is never stalled: a word arriving while the FIFO is full and
// not being popped is discarded and flagged on in_drop the following cycle.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (clears pointers, data and flags)
//   bus  : ppc_sum_if.slave (inputs in_valid/y/a/b/out_ready,
//          outputs out_valid/sum/cout/ovf/in_drop[/err])
//
// Parameter DEPTH : result-buffer entries, legal values 2, 4, 8.
// Optional feature macro PPC_SUM_ERRCHK_EN : sticky err flag raised when an
// accepted word carries any code other than 'k' or 'g'.
// ----------------------------------------------------------------------------
module ppc_sum_unit #(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    ppc_sum_if.slave bus
);
    localparam int         AW     = $clog2(DEPTH);
    localparam int         PW     = AW + 1;
    localparam logic [7:0] CODE_G = 8'h67;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } entry_t;

    genvar gi;

    // ------------------------------------------------------------------
    // Sum formation
    // ------------------------------------------------------------------
    logic [31:0] cin;
    entry_t      res_d;

    assign cin[0] = 1'b0;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_cin
            // Only a resolved 'g' produces a carry; 'k', 'p' or junk do not.
            assign cin[gi] = (bus.y[gi-1] == CODE_G);
        end
    endgenerate

    assign res_d.sum  = bus.a ^ bus.b ^ cin;
    assign res_d.cout = (bus.y[31] == CODE_G);
    assign res_d.ovf  = cin[31] ^ res_d.cout;

    // ------------------------------------------------------------------
    // FIFO control. Pointers carry one extra wrap bit so full and empty
    // are distinguishable with all DEPTH slots in use.
    // ------------------------------------------------------------------
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic          in_drop_q;
    logic          empty;
    logic          full;
    logic          pop;
    logic          wr_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && bus.out_ready;
    // A simultaneous pop frees the head slot, so a full FIFO still accepts.
    assign wr_en = bus.in_valid && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            in_drop_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            in_drop_q <= bus.in_valid && !wr_en;
        end
    end

    // ------------------------------------------------------------------
    // Storage: one register per slot, cleared by reset so the head never
    // shows X even when out_valid is low.
    // ------------------------------------------------------------------
    entry_t slot_arr [DEPTH];

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            entry_t entry_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_q <= '0;
                end else if (wr_en && (wr_ptr_q[AW-1:0] == AW'(gi))) begin
                    entry_q <= res_d;
                end
            end

            assign slot_arr[gi] = entry_q;
        end
    endgenerate

    entry_t head;
    assign head = slot_arr[rd_ptr_q[AW-1:0]];

    assign bus.out_valid = !empty;
    assign bus.sum       = head.sum;
    assign bus.cout      = head.cout;
    assign bus.ovf       = head.ovf;
    assign bus.in_drop   = in_drop_q;

`ifdef PPC_SUM_ERRCHK_EN
    // ------------------------------------------------------------------
    // Illegal-code check: an accepted word with any code other than 'k'
    // or 'g' (unresolved 'p' included) sets a flag held until reset.
    // The word itself is still buffered.
    // ------------------------------------------------------------------
    localparam logic [7:0] CODE_K = 8'h6B;

    logic [31:0] bad_code;
    logic        err_q;

    generate
        for (gi = 0; gi < 32; gi++) begin : g_chk
            assign bad_code[gi] = (bus.y[gi] != CODE_K) && (bus.y[gi] != CODE_G);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (wr_en && (|bad_code)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_ppc_sum_unit.sv
// ----------------------------------------------------------------------------
// tb_ppc_sum_unit -- self-checking bench for ppc_sum_unit (DEPTH=4).
// Operands are turned into carry codes from the true binary carries, and the
// reference model predicts results as plain a+b arithmetic held in a queue
// that follows the buffer's accept / pop / drop rules.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ppc_sum_unit;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        bad;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ppc_sum_if bus();

    ppc_sum_unit #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    word_t q[$];
    word_t cur;
`ifdef PPC_SUM_ERRCHK_EN
    logic  exp_err = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Present a word: y comes from the true carry out of each bit position;
    // bad_bit >= 0 replaces that position's code with 'p'.
    task automatic drive(input logic v, input logic [31:0] av, input logic [31:0] bv,
                         input logic rdy, input int bad_bit);
        logic [32:0] full_sum;
        logic [32:0] mask;
        logic [32:0] part;
        for (int i = 0; i < 32; i++) begin
            mask = (33'd1 << (i + 1)) - 33'd1;
            part = ({1'b0, av} & mask) + ({1'b0, bv} & mask);
            bus.y[i] = part[i+1] ? 8'h67 : 8'h6B;
        end
        if (bad_bit >= 0) begin
            bus.y[bad_bit] = 8'h70;
        end
        full_sum     = {1'b0, av} + {1'b0, bv};
        cur.sum      = full_sum[31:0];
        cur.cout     = full_sum[32];
        cur.ovf      = (av[31] == bv[31]) && (full_sum[31] != av[31]);
        cur.bad      = (bad_bit >= 0);
        bus.in_valid = v;
        bus.a        = av;
        bus.b        = bv;
        bus.out_ready = rdy;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 32'h0, 32'h0, rdy, -1);
    endtask

    // One clock: predict from the model, clock, update model, check outputs.
    task automatic cycle();
        bit    p;
        bit    w;
        bit    d;
        word_t popped;
        p = (q.size() != 0) && (bus.out_ready == 1'b1);
        w = (bus.in_valid == 1'b1) && ((q.size() < DEPTH) || p);
        d = (bus.in_valid == 1'b1) && !w;
        @(posedge clk);
        if (p) begin
            popped = q.pop_front();
            $display("POP  sum=%08h cout=%0d ovf=%0d", popped.sum, popped.cout, popped.ovf);
        end
        if (w) begin
            q.push_back(cur);
            $display("PUSH sum=%08h cout=%0d ovf=%0d bad=%0d", cur.sum, cur.cout, cur.ovf, cur.bad);
`ifdef PPC_SUM_ERRCHK_EN
            if (cur.bad) exp_err = 1'b1;
`endif
        end
        if (d) begin
            $display("DROP sum=%08h", cur.sum);
        end
        #1;
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("sum",  64'(bus.sum),  64'(q[0].sum));
            chk("cout", 64'(bus.cout), 64'(q[0].cout));
            chk("ovf",  64'(bus.ovf),  64'(q[0].ovf));
        end
        chk("in_drop", 64'(bus.in_drop), 64'(d));
`ifdef PPC_SUM_ERRCHK_EN
        chk("err", 64'(bus.err), 64'(exp_err));
`endif
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_sum"},       64'(bus.sum),       64'd0);
        chk({tag, "_cout"},      64'(bus.cout),      64'd0);
        chk({tag, "_ovf"},       64'(bus.ovf),       64'd0);
        chk({tag, "_in_drop"},   64'(bus.in_drop),   64'd0);
`ifdef PPC_SUM_ERRCHK_EN
        chk({tag, "_err"},       64'(bus.err),       64'd0);
`endif
    endtask

    initial begin
        // Reset state
        idle(1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        rst = 1'b0;

        // Scenario 1: carry ripples through every bit; first edge after reset
        drive(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1, -1);
        cycle();
        chk("s1_sum",  64'(bus.sum),  64'h0);
        chk("s1_cout", 64'(bus.cout), 64'h1);
        chk("s1_ovf",  64'(bus.ovf),  64'h0);
        idle(1'b1);
        cycle();

        // Scenario 2: signed overflow into the MSB
        drive(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b1, -1);
        cycle();
        chk("s2_sum",  64'(bus.sum),  64'h8000_0000);
        chk("s2_cout", 64'(bus.cout), 64'h0);
        chk("s2_ovf",  64'(bus.ovf),  64'h1);
        idle(1'b1);
        cycle();

        // Scenario 3: six words with no consumer -> two drops
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, $urandom, $urandom, 1'b0, -1);
            cycle();
        end
        // Scenario 4: full with simultaneous push and pop
        drive(1'b1, $urandom, $urandom, 1'b1, -1);
        cycle();
        idle(1'b1);
        repeat (6) cycle();

        // Scenario 6: unresolved 'p' in bit 5 (bit 5 carries nothing here)
        drive(1'b1, 32'h0000_0012, 32'h0000_0001, 1'b1, 5);
        cycle();
        chk("s6_sum", 64'(bus.sum), 64'h13);
        idle(1'b1);
        repeat (3) cycle();

        // Scenario 5: three buffered words, reset pulsed between edges
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, $urandom, 1'b0, -1);
            cycle();
        end
        idle(1'b0);
        #2 rst = 1'b1;
        #1;
        check_reset_state("arst");
        #1 rst = 1'b0;
        q.delete();
`ifdef PPC_SUM_ERRCHK_EN
        exp_err = 1'b0;
`endif
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, $urandom, $urandom, 1'b0, -1);
            cycle();
        end
        idle(1'b1);
        repeat (3) cycle();

        // Random traffic with backpressure
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 1)), -1);
            cycle();
        end
        idle(1'b1);
        repeat (6) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
